// File: rtl/countdown_timer_bcd.sv
// BCD mm:ss countdown timer: loads from the set-time path, borrows down once per TICK,
// pulses DONE and holds ALARM for ALARM_TICKS ticks at 00:00. All outputs registered.
module countdown_timer_bcd #(
  parameter int ALARM_TICKS  = 10,
  parameter int SEC_TENS_MAX = 5,
  parameter int MIN_TENS_MAX = 5
) (
  input  logic       i_cp,
  input  logic       i_cr,
  input  logic       i_tick,
  input  logic       i_load,
  input  logic [7:0] i_ld_min,
  input  logic [7:0] i_ld_sec,
  input  logic       i_start,
  input  logic       i_pause,
  output logic [3:0] o_min_h,
  output logic [3:0] o_min_l,
  output logic [3:0] o_sec_h,
  output logic [3:0] o_sec_l,
  output logic       o_running,
  output logic       o_done,
  output logic       o_alarm,
  output logic       o_ld_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_t;

  localparam logic [3:0] SEC_H_RELOAD = 4'(SEC_TENS_MAX);
  localparam logic [3:0] MIN_H_LIMIT  = 4'(MIN_TENS_MAX);
  localparam logic [7:0] ALARM_LAST   = 8'(ALARM_TICKS);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_min_h, r_min_l, r_sec_h, r_sec_l;
  logic [3:0] w_min_h_nxt, w_min_l_nxt, w_sec_h_nxt, w_sec_l_nxt;
  logic [3:0] w_dec_min_h, w_dec_min_l, w_dec_sec_h, w_dec_sec_l;
  logic [7:0] r_acnt, w_acnt_nxt, w_acnt_inc;
  logic       r_running, r_done, r_alarm, r_ld_err;
  logic       w_done_nxt, w_ld_err_nxt;
  logic       w_load_ok, w_zero, w_dec_zero;
  logic       w_b_sl, w_b_sh, w_b_ml;

  assign w_load_ok = (i_ld_min[3:0] <= 4'd9) && (i_ld_min[7:4] <= MIN_H_LIMIT) &&
                     (i_ld_sec[3:0] <= 4'd9) && (i_ld_sec[7:4] <= SEC_H_RELOAD);
  assign w_zero    = (r_min_h == 4'd0) && (r_min_l == 4'd0) &&
                     (r_sec_h == 4'd0) && (r_sec_l == 4'd0);

  // Borrow chain; MIN_H cannot underflow because 00:00 is never decremented.
  assign w_b_sl      = (r_sec_l == 4'd0);
  assign w_b_sh      = w_b_sl && (r_sec_h == 4'd0);
  assign w_b_ml      = w_b_sh && (r_min_l == 4'd0);
  assign w_dec_sec_l = w_b_sl ? 4'd9 : r_sec_l - 4'd1;
  assign w_dec_sec_h = !w_b_sl ? r_sec_h : (w_b_sh ? SEC_H_RELOAD : r_sec_h - 4'd1);
  assign w_dec_min_l = !w_b_sh ? r_min_l : (w_b_ml ? 4'd9 : r_min_l - 4'd1);
  assign w_dec_min_h = w_b_ml ? r_min_h - 4'd1 : r_min_h;
  assign w_dec_zero  = (w_dec_min_h == 4'd0) && (w_dec_min_l == 4'd0) &&
                       (w_dec_sec_h == 4'd0) && (w_dec_sec_l == 4'd0);
  assign w_acnt_inc  = r_acnt + 8'd1;

  always_comb begin
    w_state_nxt  = r_state;
    w_min_h_nxt  = r_min_h;
    w_min_l_nxt  = r_min_l;
    w_sec_h_nxt  = r_sec_h;
    w_sec_l_nxt  = r_sec_l;
    w_acnt_nxt   = r_acnt;
    w_done_nxt   = 1'b0;
    w_ld_err_nxt = 1'b0;
    if (i_load && (r_state != S_RUN)) begin
      if (w_load_ok) begin
        w_min_h_nxt = i_ld_min[7:4];
        w_min_l_nxt = i_ld_min[3:0];
        w_sec_h_nxt = i_ld_sec[7:4];
        w_sec_l_nxt = i_ld_sec[3:0];
        w_state_nxt = S_IDLE;
      end else begin
        w_ld_err_nxt = 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE, S_PAUSED: begin
          if (i_start && !w_zero) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (i_pause) begin
            w_state_nxt = S_PAUSED;
          end else if (i_tick) begin
            w_min_h_nxt = w_dec_min_h;
            w_min_l_nxt = w_dec_min_l;
            w_sec_h_nxt = w_dec_sec_h;
            w_sec_l_nxt = w_dec_sec_l;
            if (w_dec_zero) begin
              w_state_nxt = S_EXPIRED;
              w_done_nxt  = 1'b1;
              w_acnt_nxt  = 8'd0;
            end
          end
        end
        S_EXPIRED: begin
          if (i_start) begin
            w_state_nxt = S_IDLE;
          end else if (i_tick) begin
            w_acnt_nxt = w_acnt_inc;
            if (w_acnt_inc == ALARM_LAST) w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_cp) begin
    if (i_cr) begin
      r_state   <= S_IDLE;
      r_min_h   <= 4'd0;
      r_min_l   <= 4'd0;
      r_sec_h   <= 4'd0;
      r_sec_l   <= 4'd0;
      r_acnt    <= 8'd0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_alarm   <= 1'b0;
      r_ld_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_min_h   <= w_min_h_nxt;
      r_min_l   <= w_min_l_nxt;
      r_sec_h   <= w_sec_h_nxt;
      r_sec_l   <= w_sec_l_nxt;
      r_acnt    <= w_acnt_nxt;
      r_running <= (w_state_nxt == S_RUN);
      r_done    <= w_done_nxt;
      r_alarm   <= (w_state_nxt == S_EXPIRED);
      r_ld_err  <= w_ld_err_nxt;
    end
  end

  assign o_min_h   = r_min_h;
  assign o_min_l   = r_min_l;
  assign o_sec_h   = r_sec_h;
  assign o_sec_l   = r_sec_l;
  assign o_running = r_running;
  assign o_done    = r_done;
  assign o_alarm   = r_alarm;
  assign o_ld_err  = r_ld_err;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed and randomized checks of countdown_timer_bcd against a seconds-count reference model.
module tb_countdown_timer_bcd;

  localparam int ALARM_N = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

  logic       clk = 1'b0;
  logic       cr, tick, load, start, pause;
  logic [7:0] ld_min, ld_sec;
  logic [3:0] min_h, min_l, sec_h, sec_l;
  logic       running, done, alarm, ld_err;
  logic [15:0] dig;

  int n_assert = 0;
  int n_fail   = 0;

  int m_state, m_secs, m_acnt;
  bit m_done, m_lderr;

  countdown_timer_bcd #(.ALARM_TICKS(ALARM_N), .SEC_TENS_MAX(5), .MIN_TENS_MAX(5)) dut (
    .i_cp(clk), .i_cr(cr), .i_tick(tick), .i_load(load),
    .i_ld_min(ld_min), .i_ld_sec(ld_sec), .i_start(start), .i_pause(pause),
    .o_min_h(min_h), .o_min_l(min_l), .o_sec_h(sec_h), .o_sec_l(sec_l),
    .o_running(running), .o_done(done), .o_alarm(alarm), .o_ld_err(ld_err)
  );

  always #5 clk = ~clk;
  assign dig = {min_h, min_l, sec_h, sec_l};

  function automatic int bcd2s(input logic [7:0] m, input logic [7:0] s);
    return (int'(m[7:4]) * 10 + int'(m[3:0])) * 60 + int'(s[7:4]) * 10 + int'(s[3:0]);
  endfunction

  function automatic logic [15:0] s2bcd(input int t);
    int mm, ss;
    mm = t / 60;
    ss = t % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Reference: the count is a plain number of seconds; the digits are derived from it.
  task automatic model(input bit c, input bit t, input bit l, input logic [7:0] m,
                       input logic [7:0] s, input bit st, input bit p);
    bit ok;
    m_done  = 0;
    m_lderr = 0;
    if (c) begin
      m_state = M_IDLE; m_secs = 0; m_acnt = 0;
      return;
    end
    ok = (m[3:0] <= 9) && (s[3:0] <= 9) && (m[7:4] <= 5) && (s[7:4] <= 5);
    if (l && m_state != M_RUN) begin
      if (ok) begin m_secs = bcd2s(m, s); m_state = M_IDLE; end
      else m_lderr = 1;
      return;
    end
    case (m_state)
      M_IDLE, M_PAUSED: if (st && m_secs != 0) m_state = M_RUN;
      M_RUN: begin
        if (p) m_state = M_PAUSED;
        else if (t) begin
          m_secs = m_secs - 1;
          if (m_secs == 0) begin m_state = M_EXP; m_done = 1; m_acnt = 0; end
        end
      end
      default: begin
        if (st) m_state = M_IDLE;
        else if (t) begin
          m_acnt++;
          if (m_acnt == ALARM_N) m_state = M_IDLE;
        end
      end
    endcase
  endtask

  task automatic check(input string tag);
    logic [15:0] exp_dig;
    exp_dig = s2bcd(m_secs);
    n_assert++;
    assert (dig === exp_dig) else begin n_fail++; $error("FAIL %s digits: got %h expected %h", tag, dig, exp_dig); end
    n_assert++;
    assert (running === (m_state == M_RUN)) else begin n_fail++; $error("FAIL %s running: got %b expected %b", tag, running, m_state == M_RUN); end
    n_assert++;
    assert (done === m_done) else begin n_fail++; $error("FAIL %s done: got %b expected %b", tag, done, m_done); end
    n_assert++;
    assert (alarm === (m_state == M_EXP)) else begin n_fail++; $error("FAIL %s alarm: got %b expected %b", tag, alarm, m_state == M_EXP); end
    n_assert++;
    assert (ld_err === m_lderr) else begin n_fail++; $error("FAIL %s ld_err: got %b expected %b", tag, ld_err, m_lderr); end
  endtask

  task automatic chk_dig(input string tag, input logic [15:0] exp_dig);
    n_assert++;
    assert (dig === exp_dig) else begin n_fail++; $error("FAIL %s const digits: got %h expected %h", tag, dig, exp_dig); end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp_b);
    n_assert++;
    assert (got === exp_b) else begin n_fail++; $error("FAIL %s const flag: got %b expected %b", tag, got, exp_b); end
  endtask

  task automatic cyc(input string tag, input bit c, input bit t, input bit l,
                     input logic [7:0] m, input logic [7:0] s, input bit st, input bit p);
    cr = c; tick = t; load = l; ld_min = m; ld_sec = s; start = st; pause = p;
    model(c, t, l, m, s, st, p);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic do_idle(input string tag);  cyc(tag, 0, 0, 0, 8'h00, 8'h00, 0, 0); endtask
  task automatic do_tick(input string tag);  cyc(tag, 0, 1, 0, 8'h00, 8'h00, 0, 0); endtask
  task automatic do_start(input string tag); cyc(tag, 0, 0, 0, 8'h00, 8'h00, 1, 0); endtask
  task automatic do_pause(input string tag); cyc(tag, 0, 0, 0, 8'h00, 8'h00, 0, 1); endtask
  task automatic do_load(input string tag, input logic [7:0] m, input logic [7:0] s);
    cyc(tag, 0, 0, 1, m, s, 0, 0);
  endtask

  initial begin
    cr = 1; tick = 0; load = 0; ld_min = 0; ld_sec = 0; start = 0; pause = 0;
    m_state = M_IDLE; m_secs = 0; m_acnt = 0; m_done = 0; m_lderr = 0;

    cyc("reset0", 1, 0, 0, 8'h00, 8'h00, 0, 0);
    cyc("reset1", 1, 0, 1, 8'h12, 8'h34, 1, 0);
    chk_dig("reset", 16'h0000);
    chk_bit("reset_alarm", alarm, 1'b0);

    do_load("load_0100", 8'h01, 8'h00);
    chk_dig("load_0100", 16'h0100);
    do_start("start_0100");
    do_tick("tick_0059");
    chk_dig("tick_0059", 16'h0059);
    chk_bit("tick_0059_run", running, 1'b1);

    do_pause("pause_a");
    do_load("load_0003", 8'h00, 8'h03);
    do_start("start_0003");
    for (int i = 0; i < 3; i++) begin
      do_tick("cnt3_tick");
      if (i == 2) chk_bit("done_on_third", done, 1'b1);
      do_idle("cnt3_gap");
      chk_bit("done_one_cycle", done, 1'b0);
    end
    for (int i = 0; i < ALARM_N; i++) begin
      chk_bit("alarm_held", alarm, 1'b1);
      do_tick("alarm_tick");
      do_idle("alarm_gap");
    end
    chk_bit("alarm_dropped", alarm, 1'b0);
    chk_dig("alarm_end_zero", 16'h0000);

    do_load("load_1000", 8'h10, 8'h00);
    do_start("start_1000");
    do_tick("tick_0959");
    chk_dig("borrow_chain", 16'h0959);

    do_pause("pause_b");
    do_load("load_0005", 8'h00, 8'h05);
    do_start("start_0005");
    cyc("pause_tick", 0, 1, 0, 8'h00, 8'h00, 1, 1);
    chk_dig("pause_hold", 16'h0005);
    chk_bit("pause_notrun", running, 1'b0);
    do_tick("paused_tick1");
    do_tick("paused_tick2");
    do_start("resume");
    do_tick("tick_0004");
    chk_dig("resume_tick", 16'h0004);

    do_pause("pause_c");
    do_load("bad_min", 8'h60, 8'h00);
    chk_bit("bad_min_err", ld_err, 1'b1);
    do_idle("err_gap");
    do_load("bad_sec", 8'h00, 8'h6A);
    chk_bit("bad_sec_err", ld_err, 1'b1);
    do_start("start_run");
    do_load("load_in_run", 8'h00, 8'h30);
    chk_bit("run_load_noerr", ld_err, 1'b0);
    chk_dig("run_load_ignored", 16'h0004);

    do_pause("pause_d");
    do_load("load_0001", 8'h00, 8'h01);
    do_start("start_0001");
    do_tick("expire");
    for (int i = 0; i < 3; i++) do_tick("exp_tick");
    do_start("alarm_ack");
    chk_bit("ack_alarm", alarm, 1'b0);
    do_start("start_at_zero");
    chk_bit("zero_no_done", done, 1'b0);
    chk_bit("zero_no_run", running, 1'b0);

    do_load("load_1234", 8'h12, 8'h34);
    do_start("start_1234");
    cyc("cr_mid_run", 1, 1, 1, 8'h00, 8'h10, 0, 0);
    chk_dig("cr_zero", 16'h0000);
    chk_bit("cr_idle", running, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      bit c, t, l, st, p;
      logic [7:0] m, s;
      c  = ($urandom_range(0, 299) == 0);
      t  = ($urandom_range(0, 2) == 0);
      l  = ($urandom_range(0, 24) == 0);
      st = ($urandom_range(0, 7) == 0);
      p  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) begin
        m = 8'($urandom);
        s = 8'($urandom);
      end else begin
        m = {4'd0, 4'($urandom_range(0, 1))};
        s = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      end
      cyc("random", c, t, l, m, s, st, p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer_bcd.md
Name: countdown_timer_bcd

Overview:
- Minutes:seconds BCD countdown timer (00:00 to 59:59) for the clock project; the down-counting counterpart of the up-counting time-of-day digit chain.
- Loaded from the set-time path, decrements once per 1 Hz TICK enable, raises a DONE pulse and a timed ALARM at 00:00.
- Digit outputs feed the existing seven-segment scan/decoder unchanged.

Parameters:
- ALARM_TICKS, 10, number of TICK enables ALARM stays high after expiry (1..255).
- SEC_TENS_MAX, 5, maximum seconds-tens digit; also the reload value on seconds borrow.
- MIN_TENS_MAX, 5, maximum minutes-tens digit accepted on load.

Ports:
- CP  input  1  system clock; all logic on its rising edge.
- CR  input  1  reset, synchronous, active-high.
- TICK  input  1  one-CP-wide 1 Hz enable.
- LOAD  input  1  load request.
- LD_MIN  input  8  BCD minutes {tens, units} for LOAD.
- LD_SEC  input  8  BCD seconds {tens, units} for LOAD.
- START  input  1  start/resume request; also acknowledges the alarm.
- PAUSE  input  1  pause request.
- MIN_H, MIN_L, SEC_H, SEC_L  output  4 each  current BCD digits.
- RUNNING  output  1  high in RUN state.
- DONE  output  1  one-CP pulse on reaching 00:00.
- ALARM  output  1  level, high in EXPIRED state.
- LD_ERR  output  1  one-CP pulse on rejected LOAD.

Behaviour:
- Single clock domain. CR has highest priority, including mid-count and mid-alarm. Reset values: all digits 0, state IDLE, RUNNING 0, DONE 0, ALARM 0, LD_ERR 0, alarm counter 0.
- All outputs are registered. Control inputs take effect on the CP edge where they are sampled; outputs change the same edge, with no added latency.
- States:
  - IDLE: digits hold; TICK ignored.
  - RUN: decrements on TICK.
  - PAUSED: digits hold; TICK ignored.
  - EXPIRED: ALARM high; counts TICKs.
- LOAD (IDLE, PAUSED, EXPIRED only; ignored in RUN):
  - Valid load: every units digit ≤9, SEC tens ≤SEC_TENS_MAX, MIN tens ≤MIN_TENS_MAX. Digits take the load value and the state becomes IDLE. In EXPIRED, a valid load also clears ALARM.
  - Invalid load: digits and state unchanged, LD_ERR pulses one cycle.
- START:
  - From IDLE or PAUSED with count ≠00:00: go to RUN.
  - With count =00:00: ignored, and no DONE is generated.
  - In EXPIRED: clears ALARM and goes to IDLE; digits stay 00:00.
  - In RUN: no effect.
- PAUSE: RUN to PAUSED; no effect in other states.
- Simultaneous events:
  - PAUSE beats START and TICK in the same cycle; no decrement occurs on that edge.
  - LOAD beats START; START is dropped that cycle.
  - LOAD with CR: CR wins.
- Decrement in RUN on TICK (borrow chain):
  - SEC_L: if 0, becomes 9 and borrows; else −1.
  - SEC_H: decremented only on borrow from SEC_L. If 0, becomes SEC_TENS_MAX and borrows; else −1.
  - MIN_L: decremented only on borrow from SEC_H. If 0, becomes 9 and borrows; else −1.
  - MIN_H: decremented only on borrow from MIN_L. Never underflows, because 00:00 is never decremented.
- Expiry: the tick that produces 00:00 also moves the state to EXPIRED on the same edge. DONE is high for exactly that one cycle, ALARM rises, and the alarm counter is cleared.
- EXPIRED:
  - Each TICK increments the alarm counter.
  - On the ALARM_TICKS-th TICK, ALARM drops and the state becomes IDLE.
  - START or a valid LOAD ends the alarm early.
- Digits never hold a non-BCD value. Seconds tens never exceeds SEC_TENS_MAX.

Test Plan:
- CR high 2 cycles, then LOAD with LD_MIN=8'h01, LD_SEC=8'h00 → digits 0,1,0,0 in IDLE. START, then 1 TICK → 00:59 (SEC_H=5, SEC_L=9), RUNNING=1.
- LOAD 00:03, START, 3 TICKs → 00:02, 00:01, 00:00. DONE is high exactly on the 3rd-tick edge for one CP. ALARM high for 10 TICKs, then low with state IDLE. Digits stay 00:00.
- LOAD 10:00, START, 1 TICK → 09:59, exercising the full borrow chain across all four digits.
- RUN at 00:05: assert PAUSE and TICK in the same cycle → stays 00:05, RUNNING=0. Two further TICKs → no change. START → resumes; next TICK → 00:04.
- LOAD 8'h60:8'h00 → LD_ERR one-cycle pulse, digits unchanged. LOAD 00:6A → LD_ERR pulse. LOAD during RUN → ignored, no LD_ERR.
- Expiry then 3 TICKs, then START → ALARM drops immediately, state IDLE. START at 00:00 → stays IDLE, no DONE. CR asserted mid-RUN at 12:34 → next edge shows all zero with state IDLE.
